// File: rtl/qrange_nd_pkg.sv
// Shared types and per-dimension compare helpers for the nested range generator.
// Fields are carried internally in a widened signed form so that one set of
// signed comparisons covers both signed and unsigned operation without wrap.
package qrange_nd_pkg;

  localparam int W_MAX   = 16;          // widest supported field width
  localparam int DIM_MAX = 4;           // deepest supported nesting
  localparam int XW      = W_MAX + 2;   // room for W+1 arithmetic plus a sign

  typedef logic signed [XW-1:0] ext_t;

  typedef struct packed {
    ext_t incr;
    ext_t stop;
    ext_t start;
  } dim_cfg_t;

  typedef dim_cfg_t [DIM_MAX-1:0] cfg_t;

  // Widen a w-bit field: sign-extend when sgn, zero-extend otherwise.
  function automatic ext_t ext_field(input logic [W_MAX-1:0] raw,
                                     input int unsigned      w,
                                     input logic             sgn);
    logic [XW-1:0]    hi_mask;
    logic [W_MAX-1:0] top;
    ext_t             r;
    hi_mask = {XW{1'b1}} << w;
    top     = raw >> (w - 1);
    r       = ext_t'({{(XW-W_MAX){1'b0}}, raw}) & ~hi_mask;
    if (sgn && top[0]) begin
      r = r | hi_mask;
    end else begin
      r = r;
    end
    return r;
  endfunction

  // True when the value after this step would leave the range.
  function automatic logic dim_last(input ext_t nxt, input ext_t stop,
                                    input ext_t incr, input logic incl);
    logic r;
    if (incr == {XW{1'b0}}) begin
      r = 1'b1;
    end else if (!incr[XW-1]) begin
      r = incl ? (nxt > stop) : (nxt >= stop);
    end else begin
      r = incl ? (nxt < stop) : (nxt <= stop);
    end
    return r;
  endfunction

  // True when start is already outside the range in the incr direction.
  function automatic logic dim_empty(input ext_t start, input ext_t stop,
                                     input ext_t incr, input logic incl);
    logic r;
    if (!incr[XW-1]) begin
      r = incl ? (start > stop) : (start >= stop);
    end else begin
      r = incl ? (start < stop) : (start <= stop);
    end
    return r;
  endfunction

endpackage

// File: rtl/qrange_nd_if.sv
// Valid/ready transfer bundle used for both the cfg input and the dout output.
interface qrange_nd_if #(parameter int WD = 1);
  logic          valid;
  logic          ready;
  logic [WD-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/qrange_nd_dim.sv
// One dimension of the sweep: current value register, next/last/empty decode
// and the load/step/hold/clear selection driven by the top-level encoder.
module qrange_dim
  import qrange_nd_pkg::*;
#(
  parameter int W         = 16,   // must not exceed W_MAX
  parameter bit SIGNED    = 1'b0,
  parameter bit INCLUSIVE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] start_i,
  input  logic [W-1:0] stop_i,
  input  logic [W-1:0] incr_i,
  input  logic         started_i,
  input  logic         step_i,
  input  logic         load_i,
  input  logic         clear_i,
  output logic [W-1:0] val_o,
  output logic         last_o,
  output logic         empty_o
);

  dim_cfg_t     dcfg_s;
  ext_t         val_x_s;
  ext_t         nxt_x_s;
  logic [W-1:0] val_s;
  logic [W-1:0] cur_q;
  logic [W-1:0] cur_d;

  assign dcfg_s.start = ext_field(W_MAX'(start_i), W, SIGNED);
  assign dcfg_s.stop  = ext_field(W_MAX'(stop_i),  W, SIGNED);
  assign dcfg_s.incr  = ext_field(W_MAX'(incr_i),  W, SIGNED);

  assign val_s   = started_i ? cur_q : start_i;
  assign val_x_s = ext_field(W_MAX'(val_s), W, SIGNED);
  assign nxt_x_s = val_x_s + dcfg_s.incr;

  assign val_o   = val_s;
  assign last_o  = dim_last(nxt_x_s, dcfg_s.stop, dcfg_s.incr, INCLUSIVE);
  assign empty_o = dim_empty(dcfg_s.start, dcfg_s.stop, dcfg_s.incr, INCLUSIVE);

  // Next value: clear after the sweep, step, rewind to start, else keep the
  // presented value (which captures start for outer dims on the first beat).
  always_comb begin
    cur_d = val_s;
    if (clear_i) begin
      cur_d = {W{1'b0}};
    end else if (step_i) begin
      cur_d = nxt_x_s[W-1:0];
    end else if (load_i) begin
      cur_d = start_i;
    end else begin
      cur_d = val_s;
    end
  end

  // Current value register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= {W{1'b0}};
    end else begin
      cur_q <= cur_d;
    end
  end

endmodule

// File: rtl/qrange_nd.sv
// Multi-dimensional range generator: sweeps the cartesian product of DIM
// ranges from one cfg transaction, innermost dimension first, zero latency.
module qrange_nd
  import qrange_nd_pkg::*;
#(
  parameter int DIM       = 2,
  parameter int W         = 16,
  parameter bit SIGNED    = 1'b0,
  parameter bit INCLUSIVE = 1'b0
) (
  input logic        clk,
  input logic        rst,
  qrange_nd_if.slave  cfg,
  qrange_nd_if.master dout
);

  logic [DIM-1:0]        last_s;
  logic [DIM-1:0]        empty_s;
  logic [DIM-1:0]        eot_s;
  logic [DIM-1:0]        step_s;
  logic [DIM-1:0]        load_s;
  logic [DIM-1:0][W-1:0] val_s;
  logic                  any_empty_s;
  logic                  hs_s;
  logic                  done_s;
  logic                  started_q;
  logic                  started_d;

  for (genvar d = 0; d < DIM; d++) begin : g_dim
    qrange_dim #(.W(W), .SIGNED(SIGNED), .INCLUSIVE(INCLUSIVE)) u_dim (
      .clk       (clk),
      .rst       (rst),
      .start_i   (cfg.data[3*W*d +: W]),
      .stop_i    (cfg.data[3*W*d + W +: W]),
      .incr_i    (cfg.data[3*W*d + 2*W +: W]),
      .started_i (started_q),
      .step_i    (step_s[d]),
      .load_i    (load_s[d]),
      .clear_i   (done_s),
      .val_o     (val_s[d]),
      .last_o    (last_s[d]),
      .empty_o   (empty_s[d])
    );
  end

  assign any_empty_s = |empty_s;
  assign dout.valid  = cfg.valid & ~any_empty_s;
  assign dout.data   = {eot_s, val_s};
  assign hs_s        = dout.valid & dout.ready;
  assign done_s      = hs_s & eot_s[DIM-1];
  assign cfg.ready   = ~rst & (done_s | (cfg.valid & any_empty_s));

  // End-of-transfer chain: eot[d] is the AND of last[0..d].
  always_comb begin
    logic run_v;
    run_v = 1'b1;
    eot_s = {DIM{1'b0}};
    for (int d = 0; d < DIM; d++) begin
      run_v    = run_v & last_s[d];
      eot_s[d] = run_v;
    end
  end

  // Lowest non-last dimension steps; every dimension below it rewinds.
  always_comb begin
    logic below_v;
    below_v = 1'b1;
    step_s  = {DIM{1'b0}};
    load_s  = {DIM{1'b0}};
    for (int d = 0; d < DIM; d++) begin
      step_s[d] = hs_s & below_v & ~last_s[d];
      load_s[d] = hs_s & eot_s[d] & ~eot_s[DIM-1];
      below_v   = eot_s[d];
    end
  end

  // Started flag: set by any beat, cleared by the final beat.
  always_comb begin
    started_d = started_q;
    if (done_s) begin
      started_d = 1'b0;
    end else if (hs_s) begin
      started_d = 1'b1;
    end else begin
      started_d = started_q;
    end
  end

  // Started flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      started_q <= 1'b0;
    end else begin
      started_q <= started_d;
    end
  end

endmodule

// File: tb/tb_qrange_nd.sv
// Self-checking bench for qrange_nd: four parameterisations share one clock,
// a table of hand-computed sweeps, a reset sequence and random configs
// checked beat by beat against a nested-loop reference model.
module tb_qrange_nd;

  typedef logic [3:0][31:0] quad_t;

  typedef struct packed {
    logic [31:0] sel;
    logic [31:0] dim;
    logic [31:0] w;
    logic        incl;
    quad_t       st;
    quad_t       sp;
    quad_t       inc;
    logic [31:0] rdy;
    logic [31:0] nbeats;
    logic [67:0] last_word;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [191:0] cfg_bus;
  logic [3:0]   cfg_v;
  logic         dout_rdy;
  int           sel;
  logic         o_valid;
  logic         o_cready;
  logic [67:0]  o_data;
  int           n_tests = 0;
  int           n_fail  = 0;

  int           vals[4][$];
  logic [67:0]  exp_q[$];

  always #5 clk = ~clk;

  qrange_nd_if #(.WD(96))  c0 ();
  qrange_nd_if #(.WD(34))  d0 ();
  qrange_nd_if #(.WD(48))  c1 ();
  qrange_nd_if #(.WD(17))  d1 ();
  qrange_nd_if #(.WD(24))  c2 ();
  qrange_nd_if #(.WD(9))   d2 ();
  qrange_nd_if #(.WD(144)) c3 ();
  qrange_nd_if #(.WD(51))  d3 ();

  assign c0.valid = cfg_v[0];  assign c0.data = cfg_bus[95:0];  assign d0.ready = dout_rdy;
  assign c1.valid = cfg_v[1];  assign c1.data = cfg_bus[47:0];  assign d1.ready = dout_rdy;
  assign c2.valid = cfg_v[2];  assign c2.data = cfg_bus[23:0];  assign d2.ready = dout_rdy;
  assign c3.valid = cfg_v[3];  assign c3.data = cfg_bus[143:0]; assign d3.ready = dout_rdy;

  qrange_nd #(.DIM(2), .W(16), .SIGNED(1'b0), .INCLUSIVE(1'b0)) u_d0 (.clk(clk), .rst(rst), .cfg(c0), .dout(d0));
  qrange_nd #(.DIM(1), .W(16), .SIGNED(1'b1), .INCLUSIVE(1'b1)) u_d1 (.clk(clk), .rst(rst), .cfg(c1), .dout(d1));
  qrange_nd #(.DIM(1), .W(8),  .SIGNED(1'b0), .INCLUSIVE(1'b0)) u_d2 (.clk(clk), .rst(rst), .cfg(c2), .dout(d2));
  qrange_nd #(.DIM(3), .W(16), .SIGNED(1'b0), .INCLUSIVE(1'b0)) u_d3 (.clk(clk), .rst(rst), .cfg(c3), .dout(d3));

  // Route the selected instance's outputs to the checker.
  always_comb begin
    o_valid  = 1'b0;
    o_cready = 1'b0;
    o_data   = 68'd0;
    case (sel)
      0: begin o_valid = d0.valid; o_cready = c0.ready; o_data = 68'(d0.data); end
      1: begin o_valid = d1.valid; o_cready = c1.ready; o_data = 68'(d1.data); end
      2: begin o_valid = d2.valid; o_cready = c2.ready; o_data = 68'(d2.data); end
      3: begin o_valid = d3.valid; o_cready = c3.ready; o_data = 68'(d3.data); end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic quad_t q4(input int a0, input int a1, input int a2, input int a3);
    quad_t q;
    q[0] = a0; q[1] = a1; q[2] = a2; q[3] = a3;
    return q;
  endfunction

  function automatic vec_t mk(input int s, input int dim, input int w, input bit incl,
                              input quad_t st, input quad_t sp, input quad_t inc,
                              input int rdy, input int nb, input logic [67:0] lw);
    vec_t v;
    v.sel = s; v.dim = dim; v.w = w; v.incl = incl;
    v.st = st; v.sp = sp; v.inc = inc; v.rdy = rdy;
    v.nbeats = nb; v.last_word = lw;
    return v;
  endfunction

  // Reference: list each dimension's values as an integer loop, then walk
  // the cartesian product with a mixed-radix index (dimension 0 fastest).
  task automatic build_exp(input int dim, input int w, input bit incl,
                           input quad_t st, input quad_t sp, input quad_t inc);
    int mask, total, rem, sz, dig, s, e, i, v, n, guard;
    bit run, empty, fin;
    logic [67:0] word;
    mask = (1 << w) - 1;
    total = 1;
    for (int d = 0; d < dim; d++) begin
      vals[d].delete();
      s = $signed(st[d]); e = $signed(sp[d]); i = $signed(inc[d]);
      if (i >= 0) empty = incl ? (s > e) : (s >= e);
      else        empty = incl ? (s < e) : (s <= e);
      v = s; fin = empty; guard = 0;
      while (!fin && guard < 4096) begin
        vals[d].push_back(v);
        n = v + i;
        if (i == 0)     fin = 1'b1;
        else if (i > 0) fin = incl ? (n > e) : (n >= e);
        else            fin = incl ? (n < e) : (n <= e);
        v = n; guard++;
      end
      total = total * vals[d].size();
    end
    exp_q.delete();
    for (int idx = 0; idx < total; idx++) begin
      rem = idx; word = 68'd0; run = 1'b1;
      for (int d = 0; d < dim; d++) begin
        sz  = vals[d].size();
        dig = rem % sz;
        rem = rem / sz;
        word = word | (68'(vals[d][dig] & mask) << (w * d));
        run  = run && (dig == sz - 1);
        if (run) word = word | (68'd1 << (w * dim + d));
      end
      exp_q.push_back(word);
    end
  endtask

  // Present one cfg and consume the sweep under random back-pressure.
  task automatic run_sweep(input int s, input int dim, input int w, input bit incl,
                           input quad_t st, input quad_t sp, input quad_t inc, input int rdy_pct,
                           output int beats, output logic [67:0] last_word);
    logic [191:0] m;
    int budget, cyc;
    logic hs;
    build_exp(dim, w, incl, st, sp, inc);
    beats = 0; last_word = 68'd0;
    @(negedge clk);
    sel = s;
    cfg_v = 4'b0000; cfg_v[s] = 1'b1;
    m = (192'd1 << w) - 192'd1;
    cfg_bus = 192'd0;
    for (int d = 0; d < dim; d++) begin
      cfg_bus = cfg_bus | ((192'($signed(st[d]))  & m) << (3 * w * d))
                        | ((192'($signed(sp[d]))  & m) << (3 * w * d + w))
                        | ((192'($signed(inc[d])) & m) << (3 * w * d + 2 * w));
    end
    if (exp_q.size() == 0) begin
      dout_rdy = ($urandom_range(99) < rdy_pct);
      #1;
      chk("empty_valid",  68'(o_valid),  68'd0);
      chk("empty_cready", 68'(o_cready), 68'd1);
    end else begin
      budget = exp_q.size() * 40 + 20;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < budget) begin
        if (cyc > 0) @(negedge clk);
        dout_rdy = ($urandom_range(99) < rdy_pct);
        #1;
        chk("dout_valid", 68'(o_valid), 68'd1);
        chk("dout_data", o_data, exp_q[0]);
        hs = o_valid & dout_rdy;
        chk("cfg_ready", 68'(o_cready), 68'(hs && exp_q.size() == 1));
        if (hs) begin
          last_word = o_data;
          beats++;
          void'(exp_q.pop_front());
        end
        cyc++;
      end
      if (exp_q.size() > 0) begin
        n_tests++; n_fail++;
        $display("FAIL sweep_timeout: %0d beats outstanding, required 0", exp_q.size());
      end
    end
  endtask

  vec_t        tbl[11];
  logic [67:0] sp_exp[6];

  initial begin
    int nb, s, dim, w;
    bit incl;
    quad_t st, sp, inc;
    logic [67:0] lw;

    sp_exp[0] = 68'h0_000A_0000; sp_exp[1] = 68'h0_000A_0001; sp_exp[2] = 68'h1_000A_0002;
    sp_exp[3] = 68'h0_000B_0000; sp_exp[4] = 68'h0_000B_0001; sp_exp[5] = 68'h3_000B_0002;

    tbl[0]  = mk(0, 2, 16, 1'b0, q4(0, 10, 0, 0), q4(3, 12, 0, 0), q4(1, 1, 0, 0), 100, 6, 68'h3_000B_0002);
    tbl[1]  = mk(1, 1, 16, 1'b1, q4(5, 0, 0, 0), q4(-5, 0, 0, 0), q4(-5, 0, 0, 0), 70, 3, 68'h1_FFFB);
    tbl[2]  = mk(2, 1, 8, 1'b0, q4(250, 0, 0, 0), q4(255, 0, 0, 0), q4(4, 0, 0, 0), 70, 2, 68'h1FE);
    tbl[3]  = mk(0, 2, 16, 1'b0, q4(0, 7, 0, 0), q4(3, 7, 0, 0), q4(1, 1, 0, 0), 70, 0, 68'd0);
    tbl[4]  = mk(0, 2, 16, 1'b0, q4(5, 0, 0, 0), q4(100, 2, 0, 0), q4(0, 1, 0, 0), 100, 2, 68'h3_0001_0005);
    tbl[5]  = mk(0, 2, 16, 1'b0, q4(65530, 0, 0, 0), q4(65535, 1, 0, 0), q4(3, 1, 0, 0), 100, 2, 68'h3_0000_FFFD);
    tbl[6]  = mk(1, 1, 16, 1'b1, q4(-3, 0, 0, 0), q4(2, 0, 0, 0), q4(2, 0, 0, 0), 70, 3, 68'h1_0001);
    tbl[7]  = mk(2, 1, 8, 1'b0, q4(0, 0, 0, 0), q4(255, 0, 0, 0), q4(85, 0, 0, 0), 70, 3, 68'h1AA);
    tbl[8]  = mk(3, 3, 16, 1'b0, q4(0, 0, 0, 0), q4(3, 2, 8, 0), q4(1, 1, 2, 0), 50, 24, 68'h7_0006_0001_0002);
    tbl[9]  = mk(1, 1, 16, 1'b1, q4(0, 0, 0, 0), q4(-1, 0, 0, 0), q4(1, 0, 0, 0), 70, 0, 68'd0);
    tbl[10] = mk(1, 1, 16, 1'b1, q4(7, 0, 0, 0), q4(7, 0, 0, 0), q4(0, 0, 0, 0), 70, 1, 68'h1_0007);

    // Reset state, then outputs following cfg while reset is held.
    rst = 1'b1; cfg_v = 4'b0000; cfg_bus = 192'd0; dout_rdy = 1'b0; sel = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid",  68'(o_valid),  68'd0);
    chk("rst_cready", 68'(o_cready), 68'd0);
    @(negedge clk);
    cfg_bus = {96'd0, 16'd1, 16'd12, 16'd10, 16'd1, 16'd3, 16'd0};
    cfg_v[0] = 1'b1; dout_rdy = 1'b1;
    #1;
    chk("rst_cfg_valid",  68'(o_valid),  68'd1);
    chk("rst_cfg_data",   o_data,        sp_exp[0]);
    chk("rst_cfg_cready", 68'(o_cready), 68'd0);

    // Three beats, reset on the fourth, then a full restart from start.
    @(negedge clk);
    rst = 1'b0;
    for (int b = 0; b < 3; b++) begin
      if (b > 0) @(negedge clk);
      #1;
      chk("pre_rst_data", o_data, sp_exp[b]);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_data",   o_data,        sp_exp[3]);
    chk("mid_rst_cready", 68'(o_cready), 68'd0);
    @(negedge clk);
    #1;
    chk("held_rst_data",   o_data,        sp_exp[0]);
    chk("held_rst_cready", 68'(o_cready), 68'd0);
    @(negedge clk);
    rst = 1'b0; dout_rdy = 1'b0;
    #1;
    chk("post_rst_data", o_data, sp_exp[0]);
    for (int b = 0; b < 6; b++) begin
      @(negedge clk);
      dout_rdy = 1'b1;
      #1;
      chk("restart_data",   o_data,        sp_exp[b]);
      chk("restart_cready", 68'(o_cready), 68'(b == 5));
    end

    // Table of hand-computed sweeps, applied back to back.
    for (int t = 0; t < 11; t++) begin
      run_sweep(tbl[t].sel, tbl[t].dim, tbl[t].w, tbl[t].incl, tbl[t].st, tbl[t].sp,
                tbl[t].inc, tbl[t].rdy, nb, lw);
      chk("tbl_beats", 68'(nb), 68'(tbl[t].nbeats));
      chk("tbl_last",  lw,      tbl[t].last_word);
    end

    // Random configurations against the reference model.
    for (int it = 0; it < 24; it++) begin
      s = $urandom_range(3, 1);
      st = q4(0, 0, 0, 0); sp = q4(0, 0, 0, 0); inc = q4(0, 0, 0, 0);
      case (s)
        1: begin
          dim = 1; w = 16; incl = 1'b1;
          st[0]  = int'($urandom_range(40)) - 20;
          sp[0]  = int'($urandom_range(40)) - 20;
          inc[0] = int'($urandom_range(10)) - 5;
        end
        2: begin
          dim = 1; w = 8; incl = 1'b0;
          st[0]  = $urandom_range(255, 180);
          sp[0]  = $urandom_range(255, 180);
          inc[0] = $urandom_range(80);
        end
        default: begin
          dim = 3; w = 16; incl = 1'b0;
          for (int d = 0; d < 3; d++) begin
            st[d]  = $urandom_range(6);
            sp[d]  = $urandom_range(9);
            inc[d] = $urandom_range(3);
          end
        end
      endcase
      run_sweep(s, dim, w, incl, st, sp, inc, 60, nb, lw);
    end

    @(negedge clk);
    cfg_v = 4'b0000;
    #1;
    chk("idle_valid", 68'(o_valid), 68'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qrange_nd.md
# qrange_nd

Multi-dimensional range generator. It accepts one configuration transaction on a DTI consumer interface, giving start, stop and increment for each of DIM nested dimensions. It emits the full cartesian sweep on a DTI producer interface as a level-DIM queue, innermost dimension first. It is the nested-loop successor of the single-dimension range generator and adds signed or unsigned operation, inclusive or exclusive stop, and defined handling of empty ranges.

## Interface
- DIM, 2, number of nested dimensions, 1..4; dimension 0 is the innermost.
- W, 16, width of every start, stop, incr and output value.
- SIGNED, 0, when 1, all fields are two's complement and incr may be negative.
- INCLUSIVE, 0, when 1, stop is included in the sweep; when 0, stop is excluded.
- clk  in  1  clock.
- rst  in  1  reset; rst is synchronous, active-high; clock is clk.
- cfg  dti.consumer  3*W*DIM  configuration.
  - Per dimension d, the field is {incr, stop, start} at bits [3W*(d+1)-1 : 3W*d].
- dout  dti.producer  W*DIM+DIM  output {eot[DIM-1:0], val[DIM-1], …, val[0]}.
  - val[0] occupies the LSBs.

## Operation
- Each dimension holds a value register cur[d] and a started flag; the flag is shared across dimensions.
- Value selection:
  - Not started: val[d] = start[d].
  - Started: val[d] = cur[d].
- Step arithmetic:
  - nxt[d] = val[d] + incr[d], computed in W+1 bits.
  - The extension is sign-extension when SIGNED, zero-extension otherwise.
  - Wrap-around must never produce a false "not last".
- last[d] is true when the following holds, compared in W+1 bits:
  - incr ≥ 0, exclusive: nxt ≥ stop.
  - incr ≥ 0, inclusive: nxt > stop.
  - incr < 0, exclusive: nxt ≤ stop.
  - incr < 0, inclusive: nxt < stop.
- incr = 0 makes last[d] = 1, so the dimension yields a single value.
- eot[d] = last[0] & … & last[d].
- Empty range:
  - Exclusive mode: start == stop, or start is already past stop in the incr direction.
  - Inclusive mode: start is strictly past stop.
  - If any dimension is empty, the cfg transaction produces no output: dout.valid = 0 and cfg.ready = 1 for one cycle.
- dout.valid = cfg.valid & ~empty.
- On a dout handshake (dout.valid & dout.ready), let k be the lowest dimension with last[k] = 0:
  - cur[k] ← nxt[k].
  - cur[j] ← start[j] for all j < k.
  - cur[j] holds for all j > k.
  - started ← 1.
- If eot[DIM-1] = 1 at the handshake:
  - cfg.ready = 1 in the same cycle.
  - started ← 0 and all cur ← 0.
- cfg.ready = (dout handshake & eot[DIM-1]) | (cfg.valid & empty).
- cfg must stay stable while cfg.valid is high (DTI rule); the block does not latch cfg.

## Timing
- Zero-latency: the first output is combinational from cfg in the cycle cfg.valid rises.
- Throughput: one output per cycle when dout.ready is held high.
- Back-to-back cfg transactions have no bubble: the next cfg's first value appears in the cycle after the final eot handshake.
- Reset state: started = 0 and cur = 0.
  - Outputs during reset follow cfg combinationally: dout.valid = cfg.valid & ~empty.
  - cfg.ready is forced to 0 while rst = 1.
- Reset mid-sweep restarts the sweep at start on the next cycle if cfg is still valid.
- dout.ready low stalls the sweep: registers hold and val is stable.

## Structure
- Package qrange_nd_pkg holds:
  - the typedefs dim_cfg_t {incr, stop, start} and the cfg_t array of DIM dim_cfg_t;
  - the function computing last for a single dimension.
- Sub-module qrange_dim holds the logic for one dimension:
  - the cur register, nxt/last/empty computation, and load/step/hold control.
  - It is instantiated DIM times in a generate loop.
- The top level contains the started flag, the eot chain, the lowest-non-last priority encode and the handshake logic.

## Test plan
- DIM=2, unsigned, exclusive; cfg d0=(0,3,1), d1=(10,12,1).
  - Expected output, 6 beats: (0,10) (1,10) (2,10,eot=01) (0,11) (1,11) (2,11,eot=11).
  - cfg.ready is high only on the last beat.
- SIGNED=1, INCLUSIVE=1, DIM=1; cfg (5,-5,-5) → 5, 0, -5 with eot on -5.
- Overflow: W=8, unsigned, exclusive; cfg (250,255,4) → 250, 254 with eot on 254, no wrap.
- Empty range: d1=(7,7,1) exclusive → no dout.valid, cfg.ready pulses for one cycle; a following valid cfg then sweeps normally.
- Random dout.ready back-pressure over DIM=3 ranges of sizes 3×2×4 → 24 beats in order, with values stable during stalls.
- rst asserted at the 4th beat of a 6-beat sweep → the sweep restarts at start after reset and cfg.ready stays low during reset.
